// File: rtl/img_pack_121x8_if.sv
// img_pack_121x8_if: pixel-stream input and packed-frame output bundle of the pixel packer.
interface img_pack_121x8_if #(parameter int NPIX = 121, parameter int PW = 8);
  logic [PW-1:0]      pix_in;
  logic               pix_valid;
  logic               pix_sof;
  logic               pix_ready;
  logic [NPIX*PW-1:0] img_source;
  logic               valid_top;
  logic               ready_top;
  logic [6:0]         pix_cnt;
  logic               sof_err;
  modport master (input pix_in, pix_valid, pix_sof, ready_top,
                  output pix_ready, img_source, valid_top, pix_cnt, sof_err);
  modport slave  (output pix_in, pix_valid, pix_sof, ready_top,
                  input pix_ready, img_source, valid_top, pix_cnt, sof_err);
endinterface

// File: rtl/img_pack_121x8.sv
// img_pack_121x8: packs an 11x11 raster pixel stream into a 968-bit frame with a valid/ready handoff.
// Optional PIX_SAT_EN clamps stored pixels to 127 to match the classifier's 7-bit activations.
module img_pack_121x8 #(
  parameter int NPIX = 121,
  parameter int PW   = 8
) (
  input logic             clk,
  input logic             rst,
  img_pack_121x8_if.master bus
);
  typedef enum logic {FILL, HOLD} state_t;
  state_t        state_q, state_d;
  logic [6:0]    cnt_q, cnt_d, slot;
  logic          err_q, err_d, live_q, acc;
  logic [PW-1:0] px;
  logic [PW-1:0] pix_q [NPIX];
  assign acc = bus.pix_valid && bus.pix_ready;
`ifdef PIX_SAT_EN
  localparam logic [PW-1:0] PIX_MAX = PW'(127);
  assign px = (bus.pix_in > PIX_MAX) ? PIX_MAX : bus.pix_in;
`else
  assign px = bus.pix_in;
`endif
  // A start-of-frame always lands in slot 0, restarting any partial frame.
  assign slot = bus.pix_sof ? 7'd0 : cnt_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    if (state_q == HOLD) begin
      state_d = bus.ready_top ? FILL : HOLD;
      cnt_d   = bus.ready_top ? 7'd0 : cnt_q;
    end else if (acc) begin
      cnt_d   = slot + 7'd1;
      err_d   = bus.pix_sof && (cnt_q != 7'd0);
      state_d = (slot == 7'(NPIX-1)) ? HOLD : FILL;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
      for (int i = 0; i < NPIX; i++) pix_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      live_q  <= 1'b1;
      if (acc) pix_q[slot] <= px;
    end
  end
  assign bus.pix_ready = live_q && (state_q == FILL);
  assign bus.valid_top = (state_q == HOLD);
  assign bus.pix_cnt   = cnt_q;
  assign bus.sof_err   = err_q;
  for (genvar k = 0; k < NPIX; k++) begin : g_pack
    assign bus.img_source[NPIX*PW-1-PW*k -: PW] = pix_q[k];
  end
endmodule

// File: tb/tb_img_pack_121x8.sv
// tb_img_pack_121x8: randomized self-checking bench for img_pack_121x8 against a frame-level reference model.
module tb_img_pack_121x8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  img_pack_121x8_if bus ();
  img_pack_121x8 dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int vec = 0;
  int errs = 0;
  logic [7:0] m_frame [121];
  int m_cnt;
  bit m_hold, m_live, m_err;
  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  function automatic logic [7:0] stored(logic [7:0] p);
`ifdef PIX_SAT_EN
    return (p > 8'd127) ? 8'd127 : p;
`else
    return p;
`endif
  endfunction
  function automatic logic [7:0] byte_of(logic [967:0] v, int k);
    return v[967-8*k -: 8];
  endfunction
  function automatic logic [967:0] m_img();
    logic [967:0] r;
    for (int k = 0; k < 121; k++) r[967-8*k -: 8] = m_frame[k];
    return r;
  endfunction
  function automatic string diag(logic [967:0] a, logic [967:0] b);
    for (int k = 0; k < 121; k++)
      if (byte_of(a, k) !== byte_of(b, k))
        return $sformatf("slot %0d act=%h exp=%h", k, byte_of(a, k), byte_of(b, k));
    return "no slot differs";
  endfunction
  task automatic m_reset();
    m_cnt = 0; m_hold = 0; m_live = 0; m_err = 0;
    for (int k = 0; k < 121; k++) m_frame[k] = 8'h00;
  endtask
  task automatic drive(bit v, bit s, logic [7:0] p, bit r);
    bus.pix_valid = v; bus.pix_sof = s; bus.pix_in = p; bus.ready_top = r;
  endtask
  task automatic tick();
    int s;
    m_err = 0;
    if (m_hold) begin
      if (bus.ready_top) begin m_hold = 0; m_cnt = 0; end
    end else if (m_live && bus.pix_valid) begin
      s = bus.pix_sof ? 0 : m_cnt;
      m_frame[s] = stored(bus.pix_in);
      m_err = bus.pix_sof && (m_cnt != 0);
      m_cnt = s + 1;
      m_hold = (m_cnt == 121);
    end
    m_live = 1;
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    #1 rst = 1'b1;
    drive(1, 1, 8'($urandom), 1);
    repeat (3) @(posedge clk);
    #1 m_reset();
    vec++; if (bus.valid_top !== 1'b0) begin errs++; $display("FAIL rst_valid act=%b exp=0", bus.valid_top); end
    vec++; if (bus.pix_cnt !== 7'd0) begin errs++; $display("FAIL rst_cnt act=%0d exp=0", bus.pix_cnt); end
    vec++; if (bus.img_source !== '0) begin errs++; $display("FAIL rst_img %s", diag(bus.img_source, '0)); end
    vec++; if (bus.pix_ready !== 1'b0) begin errs++; $display("FAIL rst_ready act=%b exp=0", bus.pix_ready); end
    vec++; if (bus.sof_err !== 1'b0) begin errs++; $display("FAIL rst_sof_err act=%b exp=0", bus.sof_err); end
    drive(0, 0, 8'h00, 0);
    rst = 1'b0;
    tick();
    vec++; if (bus.pix_ready !== 1'b1) begin errs++; $display("FAIL rel_ready act=%b exp=1", bus.pix_ready); end
    vec++; if (bus.pix_cnt !== 7'd0) begin errs++; $display("FAIL rel_cnt act=%0d exp=0", bus.pix_cnt); end
  endtask
  task automatic test_ramp();
    for (int k = 0; k < 121; k++) begin
      drive(1, k == 0, 8'(k), 0);
      tick();
      vec++; if (bus.pix_cnt !== 7'(k + 1)) begin errs++; $display("FAIL ramp_cnt act=%0d exp=%0d", bus.pix_cnt, k + 1); end
      vec++; if (bus.valid_top !== (k == 120)) begin errs++; $display("FAIL ramp_valid k=%0d act=%b exp=%b", k, bus.valid_top, k == 120); end
    end
    vec++; if (bus.img_source[967:960] !== 8'h00) begin errs++; $display("FAIL ramp_first act=%h exp=00", bus.img_source[967:960]); end
    vec++; if (bus.img_source[7:0] !== 8'h78) begin errs++; $display("FAIL ramp_last act=%h exp=78", bus.img_source[7:0]); end
    for (int i = 0; i < 20; i++) begin
      drive(1, 1'($urandom), 8'($urandom), 0);
      tick();
      vec++; if (bus.valid_top !== 1'b1) begin errs++; $display("FAIL hold_valid act=%b exp=1", bus.valid_top); end
      vec++; if (bus.pix_ready !== 1'b0) begin errs++; $display("FAIL hold_ready act=%b exp=0", bus.pix_ready); end
      vec++; if (bus.img_source !== m_img()) begin errs++; $display("FAIL hold_img %s", diag(bus.img_source, m_img())); end
    end
  endtask
  task automatic test_back_to_back();
    int first, second;
    logic prev;
    drive(0, 0, 8'h00, 1);
    tick();
    vec++; if (bus.valid_top !== 1'b0) begin errs++; $display("FAIL hs_valid act=%b exp=0", bus.valid_top); end
    vec++; if (bus.pix_ready !== 1'b1) begin errs++; $display("FAIL hs_ready act=%b exp=1", bus.pix_ready); end
    vec++; if (bus.pix_cnt !== 7'd0) begin errs++; $display("FAIL hs_cnt act=%0d exp=0", bus.pix_cnt); end
    first = -1; second = -1; prev = 1'b0;
    for (int c = 1; c <= 244; c++) begin
      drive(1, 0, 8'h55, 1);
      tick();
      if (bus.valid_top && !prev) begin
        if (first < 0) first = c; else if (second < 0) second = c;
        vec++; if (bus.img_source !== {121{8'h55}}) begin errs++; $display("FAIL b2b_img %s", diag(bus.img_source, {121{8'h55}})); end
      end
      prev = bus.valid_top;
      vec++; if (bus.pix_cnt !== 7'(m_cnt)) begin errs++; $display("FAIL b2b_cnt act=%0d exp=%0d", bus.pix_cnt, m_cnt); end
    end
    vec++; if (first !== 121) begin errs++; $display("FAIL b2b_first act=%0d exp=121", first); end
    vec++; if (second - first !== 122) begin errs++; $display("FAIL b2b_period act=%0d exp=122", second - first); end
    drive(0, 0, 8'h00, 0);
  endtask
  task automatic test_sof_restart();
    logic [7:0] v;
    for (int k = 0; k < 50; k++) begin
      drive(1, k == 0, 8'($urandom), 0);
      tick();
      if (k == 0) begin
        vec++; if (bus.sof_err !== 1'b0) begin errs++; $display("FAIL sof_start_err act=%b exp=0", bus.sof_err); end
      end
    end
    v = 8'($urandom);
    drive(1, 1, v, 0);
    tick();
    vec++; if (bus.sof_err !== 1'b1) begin errs++; $display("FAIL sof_err_pulse act=%b exp=1", bus.sof_err); end
    vec++; if (bus.pix_cnt !== 7'd1) begin errs++; $display("FAIL sof_cnt act=%0d exp=1", bus.pix_cnt); end
    for (int j = 0; j < 120; j++) begin
      drive(1, 0, 8'($urandom), 0);
      tick();
      if (j == 0) begin
        vec++; if (bus.sof_err !== 1'b0) begin errs++; $display("FAIL sof_err_width act=%b exp=0", bus.sof_err); end
      end
      vec++; if (bus.valid_top !== (j == 119)) begin errs++; $display("FAIL sof_valid j=%0d act=%b exp=%b", j, bus.valid_top, j == 119); end
    end
    vec++; if (bus.img_source[967:960] !== stored(v)) begin errs++; $display("FAIL sof_slot0 act=%h exp=%h", bus.img_source[967:960], stored(v)); end
    vec++; if (bus.img_source !== m_img()) begin errs++; $display("FAIL sof_img %s", diag(bus.img_source, m_img())); end
    drive(0, 0, 8'h00, 1);
    tick();
  endtask
  task automatic test_saturation();
    logic [7:0] exp_c8;
`ifdef PIX_SAT_EN
    exp_c8 = 8'h7F;
`else
    exp_c8 = 8'hC8;
`endif
    for (int k = 0; k < 121; k++) begin
      drive(1, k == 0, (k == 0) ? 8'hC8 : (k == 1) ? 8'h3F : 8'($urandom), 0);
      tick();
    end
    vec++; if (bus.img_source[967:960] !== exp_c8) begin errs++; $display("FAIL sat_c8 act=%h exp=%h", bus.img_source[967:960], exp_c8); end
    vec++; if (bus.img_source[959:952] !== 8'h3F) begin errs++; $display("FAIL sat_3f act=%h exp=3f", bus.img_source[959:952]); end
    vec++; if (bus.img_source !== m_img()) begin errs++; $display("FAIL sat_img %s", diag(bus.img_source, m_img())); end
    drive(0, 0, 8'h00, 1);
    tick();
  endtask
  task automatic async_hit(string tag);
    #2 rst = 1'b1;
    #1;
    vec++; if (bus.valid_top !== 1'b0) begin errs++; $display("FAIL %s_valid act=%b exp=0", tag, bus.valid_top); end
    vec++; if (bus.pix_cnt !== 7'd0) begin errs++; $display("FAIL %s_cnt act=%0d exp=0", tag, bus.pix_cnt); end
    vec++; if (bus.pix_ready !== 1'b0) begin errs++; $display("FAIL %s_ready act=%b exp=0", tag, bus.pix_ready); end
    vec++; if (bus.img_source !== '0) begin errs++; $display("FAIL %s_img %s", tag, diag(bus.img_source, '0)); end
    m_reset();
    drive(0, 0, 8'h00, 0);
    @(posedge clk); #1 rst = 1'b0;
    tick();
  endtask
  task automatic test_async_reset();
    for (int k = 0; k < 60; k++) begin drive(1, k == 0, 8'($urandom), 0); tick(); end
    async_hit("arst_fill");
    for (int k = 0; k < 121; k++) begin drive(1, k == 0, 8'($urandom), 0); tick(); end
    vec++; if (bus.valid_top !== 1'b1) begin errs++; $display("FAIL arst_pre_hold act=%b exp=1", bus.valid_top); end
    async_hit("arst_hold");
    for (int k = 0; k < 121; k++) begin drive(1, 0, 8'($urandom), 0); tick(); end
    vec++; if (bus.valid_top !== 1'b1) begin errs++; $display("FAIL arst_post_valid act=%b exp=1", bus.valid_top); end
    vec++; if (bus.img_source !== m_img()) begin errs++; $display("FAIL arst_post_img %s", diag(bus.img_source, m_img())); end
    drive(0, 0, 8'h00, 1);
    tick();
  endtask
  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0, 8'($urandom), $urandom_range(0, 9) < 3);
      tick();
      vec++; if (bus.valid_top !== m_hold) begin errs++; $display("FAIL rnd_valid c=%0d act=%b exp=%b", c, bus.valid_top, m_hold); end
      vec++; if (bus.pix_ready !== (m_live && !m_hold)) begin errs++; $display("FAIL rnd_ready c=%0d act=%b exp=%b", c, bus.pix_ready, m_live && !m_hold); end
      vec++; if (bus.pix_cnt !== 7'(m_cnt)) begin errs++; $display("FAIL rnd_cnt c=%0d act=%0d exp=%0d", c, bus.pix_cnt, m_cnt); end
      vec++; if (bus.sof_err !== m_err) begin errs++; $display("FAIL rnd_sof_err c=%0d act=%b exp=%b", c, bus.sof_err, m_err); end
      vec++; if (bus.img_source !== m_img()) begin errs++; $display("FAIL rnd_img c=%0d %s", c, diag(bus.img_source, m_img())); end
    end
  endtask
  initial begin
    drive(0, 0, 8'h00, 0);
    m_reset();
    test_reset();
    test_ramp();
    test_back_to_back();
    test_sof_restart();
    test_saturation();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
